// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Brief    : Shared constants and state encoding for the UART TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    localparam int c_NREQ_DEFAULT    = 4;
    localparam int c_TIMEOUT_DEFAULT = 65535;
    localparam int c_BYTE_W          = 8;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t c_ST_IDLE      = 3'd0;
    localparam arb_state_t c_ST_SEND      = 3'd1;
    localparam arb_state_t c_ST_START     = 3'd2;
    localparam arb_state_t c_ST_WAIT_BUSY = 3'd3;
    localparam arb_state_t c_ST_WAIT_DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : One-hot winner of the first asserted request scanning upward
//            from i_ptr, wrapping modulo NREQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NREQ  = c_NREQ_DEFAULT,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_winner
);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_winner = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, message-locked sharing of one UART TX byte port.
//            Define UART_ARB_TIMEOUT_EN to revoke grants idle for TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = c_NREQ_DEFAULT,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [c_BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          grant,
    output logic [c_BYTE_W-1:0]      tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     arb_timeout
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [NREQ-1:0]       r_grant;
    logic [NREQ-1:0]       w_pick;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      w_gidx;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic                  r_last;
    logic [c_BYTE_W-1:0]   r_tx_data;
    logic [c_BYTE_W-1:0]   w_gdata;
    logic                  w_gvalid;
    logic                  w_glast;
    logic                  w_xfer;
    logic                  w_done;
    logic                  w_tmo;

    rr_pick #(
        .NREQ     (NREQ)
    ) u_pick (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_winner (w_pick)
    );

    // Owner index and its byte lane, selected by the one-hot grant.
    always_comb begin
        w_gidx  = '0;
        w_gdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_gidx  = PTR_W'(i);
                w_gdata = req_data[i*c_BYTE_W +: c_BYTE_W];
            end
        end
    end

    assign w_gvalid  = |(req_valid & r_grant);
    assign w_glast   = |(req_last & r_grant);
    assign w_ptr_nxt = (w_gidx == PTR_W'(NREQ-1)) ? '0 : w_gidx + PTR_W'(1);
    assign w_xfer    = (r_state == c_ST_SEND) && w_gvalid && !tx_busy;
    assign w_done    = (r_state == c_ST_WAIT_DONE) && !tx_busy && r_last;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] r_idle_cnt;
    logic        r_timeout;

    assign w_tmo = (r_state == c_ST_SEND) && !w_gvalid &&
                   (r_idle_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_tmo;
            if ((r_state != c_ST_SEND) || (w_state_nxt != r_state) || w_gvalid) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end
        end
    end

    assign arb_timeout = r_timeout;
`else
    assign w_tmo       = 1'b0;
    assign arb_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:      if (|req_valid) w_state_nxt = c_ST_SEND;
            c_ST_SEND: begin
                if (w_tmo) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_xfer) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START:     w_state_nxt = c_ST_WAIT_BUSY;
            c_ST_WAIT_BUSY: if (tx_busy) w_state_nxt = c_ST_WAIT_DONE;
            c_ST_WAIT_DONE: if (!tx_busy) w_state_nxt = r_last ? c_ST_IDLE : c_ST_SEND;
            default:        w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Grant is held for the whole message; the finisher drops to lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant   <= '0;
            r_ptr     <= '0;
            r_last    <= 1'b0;
            r_tx_data <= '0;
        end else begin
            if ((r_state == c_ST_IDLE) && (|req_valid)) begin
                r_grant <= w_pick;
            end
            if (w_xfer) begin
                r_tx_data <= w_gdata;
                r_last    <= w_glast;
            end
            if (w_tmo || w_done) begin
                r_grant <= '0;
                r_ptr   <= w_ptr_nxt;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        tx_start  = 1'b0;
        case (r_state)
            c_ST_SEND:  req_ready = r_grant & req_valid & {NREQ{!tx_busy}};
            c_ST_START: tx_start  = 1'b1;
            default: ;
        endcase
    end

    assign grant   = r_grant;
    assign tx_data = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed and randomized checks of uart_tx_arbiter against a
//            queue-based message model and a behavioural transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic           arb_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(N), .TIMEOUT(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .arb_timeout(arb_timeout)
    );

    // Each requester owns a queue of {last, byte}; the head is what it offers.
    logic [8:0] msg_q [N][$];
    logic [7:0] exp_tx[$];
    int         grant_log[$];
    int         starts_log[$];
    bit         open_msg[N];
    int         mptr, blen, bcnt, cyc;
    int         n_vec, n_err, n_xfer, n_start;
    bit         model_busy, force_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) begin
                r[(p + k) % N] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic int owner(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            h = (msg_q[i].size() > 0) ? msg_q[i][0] : 9'h000;
            req_valid[i]       = (msg_q[i].size() > 0);
            req_data[8*i +: 8] = h[7:0];
            req_last[i]        = h[8];
        end
    endtask

    task automatic tick();
        logic [N-1:0] xfer_pre, vld_pre, grant_pre;
        logic         start_pre, rst_pre, busy_pre;
        logic [8:0]   h;
        int           ow;
        #1;
        xfer_pre  = req_valid & req_ready & {N{!rst}};
        vld_pre   = req_valid;
        grant_pre = grant;
        start_pre = tx_start;
        rst_pre   = rst;
        busy_pre  = tx_busy;
        @(posedge clk);
        #1;
        cyc++;
        if (start_pre) begin
            model_busy = 1'b1;
            bcnt = blen;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) model_busy = 1'b0;
        end
        tx_busy = model_busy | force_busy;
        if (rst_pre) begin
            exp_tx.delete();
            for (int i = 0; i < N; i++) open_msg[i] = 1'b0;
            mptr = 0;
            check("rst_grant", grant, 0);
            check("rst_ready", req_ready, 0);
            check("rst_start", tx_start, 0);
            check("rst_timeout", arb_timeout, 0);
        end else begin
            for (int i = 0; i < N; i++) begin
                if (xfer_pre[i]) begin
                    check("xfer_owner", grant_pre, 1 << i);
                    h = msg_q[i].pop_front();
                    exp_tx.push_back(h[7:0]);
                    n_xfer++;
                    open_msg[i] = !h[8];
                    if (h[8]) mptr = (i + 1) % N;
                end
            end
            if (tx_start) begin
                n_start++;
                if (starts_log.size() > 0) starts_log[starts_log.size()-1]++;
                check("start_pending", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0) check("tx_data", tx_data, exp_tx.pop_front());
            end
            if (grant_pre == 0) begin
                check("arb_pick", grant, ref_pick(vld_pre, mptr));
                if (grant != 0) begin
                    grant_log.push_back(owner(grant));
                    starts_log.push_back(0);
                end
            end else if (grant != grant_pre) begin
                ow = owner(grant_pre);
                check("release_to_idle", grant, 0);
                if (arb_timeout) begin
                    mptr = (ow + 1) % N;
                    open_msg[ow] = 1'b0;
                end else begin
                    check("release_msg_done", open_msg[ow], 0);
                    check("release_tx_idle", busy_pre, 0);
                end
            end
            check("ready_mask", req_ready & ~grant, 0);
`ifndef UART_ARB_TIMEOUT_EN
            check("no_timeout", arb_timeout, 0);
`endif
        end
        drive();
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((grant != 0 || tx_busy || req_valid != 0) && k < 3000) begin
            tick();
            k++;
        end
        check("idle_reached", {grant != 0, tx_busy, req_valid != 0}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, idx3, m, r, len;
        int t3_starts[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};

        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        blen = 3; bcnt = 0; model_busy = 1'b0; force_busy = 1'b0;
        repeat (3) tick();
        check("reset_tx_data", tx_data, 8'h00);
        rst = 1'b0;

        // Single requester, one byte
        blen = 10;
        msg_q[1].push_back({1'b1, 8'h49});
        drive();
        tick();
        check("t1_grant", grant, 4'b0010);
        check("t1_ready", req_ready, 4'b0010);
        tick();
        check("t1_start", tx_start, 1);
        check("t1_data", tx_data, 8'h49);
        tick();
        k = 0;
        while (tx_busy && k < 40) begin tick(); k++; end
        check("t1_busy_fall", tx_busy, 0);
        check("t1_hold", grant, 4'b0010);
        tick();
        check("t1_release", grant, 4'b0000);

        // Multi-byte lock while requester 2 waits
        blen = 4;
        msg_q[0].push_back({1'b0, 8'h49});
        msg_q[0].push_back({1'b1, 8'h31});
        drive();
        tick();
        check("t3_grant0", grant, 4'b0001);
        idx3 = grant_log.size() - 1;
        msg_q[2].push_back({1'b1, 8'hA5});
        drive();
        k = 0;
        while (grant != 4'b0100 && k < 80) begin
            tick();
            if (tx_start && grant == 4'b0001) t3_starts.push_back(cyc);
            k++;
        end
        check("t3_next_owner", grant, 4'b0100);
        check("t3_bytes_under_lock", starts_log[idx3], 2);
        if (t3_starts.size() == 2) check("t3_back_to_back", t3_starts[1] - t3_starts[0], blen + 3);
        else check("t3_start_count", t3_starts.size(), 2);
        wait_idle();

        // Round-robin fairness from ptr = 0
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        grant_log.delete();
        starts_log.delete();
        blen = 2;
        msg_q[0].push_back({1'b1, 8'h10});
        msg_q[0].push_back({1'b1, 8'h14});
        msg_q[1].push_back({1'b1, 8'h11});
        msg_q[2].push_back({1'b1, 8'h12});
        msg_q[3].push_back({1'b1, 8'h13});
        drive();
        wait_idle();
        check("t4_grant_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) begin
                check("t4_order", grant_log[i], exp_order[i]);
                check("t4_one_start", starts_log[i], 1);
            end
        end

        // Busy hold-off on entry to SEND
        force_busy = 1'b1;
        tx_busy = 1'b1;
        msg_q[1].push_back({1'b1, 8'h5A});
        drive();
        tick();
        check("t5_grant", grant, 4'b0010);
        check("t5_ready_low", req_ready, 0);
        repeat (3) begin
            tick();
            check("t5_ready_held", req_ready, 0);
        end
        force_busy = 1'b0;
        tx_busy = model_busy;
        #1;
        check("t5_ready_pulse", req_ready, 4'b0010);
        tick();
        check("t5_ready_drop", req_ready, 0);
        check("t5_start", tx_start, 1);
        wait_idle();

        // Reset during WAIT_DONE of a 3-byte message
        blen = 6;
        msg_q[3].push_back({1'b0, 8'h31});
        msg_q[3].push_back({1'b0, 8'h32});
        msg_q[3].push_back({1'b1, 8'h33});
        drive();
        k = 0;
        while (!tx_start && k < 20) begin tick(); k++; end
        check("t6_first_start", tx_start, 1);
        tick();
        tick();
        msg_q[0].push_back({1'b1, 8'h40});
        msg_q[2].push_back({1'b1, 8'h42});
        drive();
        rst = 1'b1;
        tick();
        check("t6_grant", grant, 0);
        check("t6_ready", req_ready, 0);
        check("t6_start", tx_start, 0);
        rst = 1'b0;
        k = 0;
        while (grant == 0 && k < 20) begin tick(); k++; end
        check("t6_winner", grant, 4'b0001);
        wait_idle();

`ifdef UART_ARB_TIMEOUT_EN
        // Revocation of an idle held grant
        blen = 3;
        msg_q[3].push_back({1'b0, 8'h77});
        drive();
        k = 0;
        while (!tx_start && k < 20) begin tick(); k++; end
        check("t8_start", tx_start, 1);
        tick();
        k = 0;
        while (tx_busy && k < 20) begin tick(); k++; end
        repeat (5) begin
            tick();
            check("t8_quiet", arb_timeout, 0);
        end
        tick();
        check("t8_pulse", arb_timeout, 1);
        check("t8_grant_clear", grant, 0);
        tick();
        check("t8_pulse_end", arb_timeout, 0);
        msg_q[0].push_back({1'b1, 8'h50});
        msg_q[1].push_back({1'b1, 8'h51});
        drive();
        k = 0;
        while (grant == 0 && k < 20) begin tick(); k++; end
        check("t8_ptr_wrap", grant, 4'b0001);
        wait_idle();
`endif

        // Randomized traffic with staggered arrivals
        m = 0;
        k = 0;
        while ((m < 40 || grant != 0 || tx_busy || req_valid != 0) && k < 6000) begin
            if (m < 40 && $urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, N - 1);
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++)
                    msg_q[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                m++;
                drive();
            end
            if ($urandom_range(0, 7) == 0) blen = $urandom_range(1, 5);
            tick();
            k++;
        end
        check("rand_drained", {grant != 0, tx_busy, req_valid != 0}, 0);
        check("start_per_xfer", n_start, n_xfer);
        check("tx_queue_empty", exp_tx.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
